// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC and runs a req/ack handshake with a
// variable-latency instruction memory, delivering words to the IF/ID boundary.
module fetch_ctrl #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [N-1:0]     branch_addr,
  output logic             mem_req,
  output logic [N-1:0]     mem_addr,
  input  logic             mem_ack,
  input  logic [N-1:0]     mem_rdata,
  output logic             if_valid,
  output logic [N-1:0]     if_instr,
  output logic [N-1:0]     if_pc,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

  state_t           r_state;
  logic [N-1:0]     r_pc;
  logic             r_memReq;
  logic [N-1:0]     r_memAddr;
  logic             r_ifValid;
  logic [N-1:0]     r_ifInstr;
  logic [N-1:0]     r_ifPc;
  logic [CNT_W-1:0] r_fetchCount;
  logic [CNT_W-1:0] r_flushCount;

  logic [N-1:0]     w_nextPc;

  assign w_nextPc = r_memAddr + N'(4);

  // A request, once issued, is held with a stable address until its ack
  // arrives; redirects during that window are parked in r_pc (DISCARD).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_memReq     <= 1'b0;
      r_memAddr    <= '0;
      r_ifValid    <= 1'b0;
      r_ifInstr    <= '0;
      r_ifPc       <= '0;
      r_fetchCount <= '0;
      r_flushCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state   <= REQ;
          r_memReq  <= 1'b1;
          r_memAddr <= r_pc;
        end
        REQ: begin
          if (mem_ack && !branch_taken) begin
            r_ifInstr <= mem_rdata;
            r_ifPc    <= w_nextPc;
            r_ifValid <= 1'b1;
            r_pc      <= w_nextPc;
            r_memReq  <= 1'b0;
            r_state   <= HOLD;
          end else if (mem_ack) begin
            r_flushCount <= r_flushCount + CNT_W'(1);
            r_pc         <= branch_addr;
            r_memAddr    <= branch_addr;
            r_state      <= REQ;
          end else if (branch_taken) begin
            r_pc    <= branch_addr;
            r_state <= DISCARD;
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            r_flushCount <= r_flushCount + CNT_W'(1);
            r_state      <= REQ;
            if (branch_taken) begin
              r_pc      <= branch_addr;
              r_memAddr <= branch_addr;
            end else begin
              r_memAddr <= r_pc;
            end
          end else if (branch_taken) begin
            r_pc <= branch_addr;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            r_ifValid    <= 1'b0;
            r_flushCount <= r_flushCount + CNT_W'(1);
            r_pc         <= branch_addr;
            r_memAddr    <= branch_addr;
            r_memReq     <= 1'b1;
            r_state      <= REQ;
          end else if (!freeze) begin
            r_fetchCount <= r_fetchCount + CNT_W'(1);
            r_ifValid    <= 1'b0;
            r_memAddr    <= r_pc;
            r_memReq     <= 1'b1;
            r_state      <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req     = r_memReq;
  assign mem_addr    = r_memAddr;
  assign if_valid    = r_ifValid;
  assign if_instr    = r_ifInstr;
  assign if_pc       = r_ifPc;
  assign fetch_count = r_fetchCount;
  assign flush_count = r_flushCount;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural instruction memory whose
// ack latency is set per scenario; expected values are hand-derived per cycle.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [15:0] fetch_count;
  logic [15:0] flush_count;

  int errCount   = 0;
  int checkCount = 0;
  int memLat     = 1;
  int memCnt     = 0;
  bit memEnable  = 0;
  bit strayAck   = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_count(fetch_count), .flush_count(flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr == 32'h0) ? 32'hE3A01005 : (addr ^ 32'h5A5A_0000);
  endfunction

  // Memory answers on the falling edge so the ack is seen at the next rising edge.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req || !memEnable) begin
        memCnt  = 0;
        mem_ack = strayAck;
      end else begin
        memCnt++;
        if (memCnt >= memLat) begin
          mem_ack   = 1'b1;
          mem_rdata = memWord(mem_addr);
          memCnt    = 0;
        end else begin
          mem_ack = strayAck;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic b, input logic [31:0] addr);
    freeze       = f;
    branch_taken = b;
    branch_addr  = addr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int lat);
    rst       = 1'b1;
    memEnable = 1'b0;
    applyStimulus(0, 0, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_if_valid", if_valid, 0);
    checkOutput("rst_if_instr", if_instr, 0);
    checkOutput("rst_if_pc", if_pc, 0);
    checkOutput("rst_fetch_cnt", fetch_count, 0);
    checkOutput("rst_flush_cnt", flush_count, 0);
    memLat    = lat;
    memEnable = 1'b1;
    rst       = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0);

    // Zero-wait memory: one delivery every two cycles.
    doReset(1);
    stepCycle();
    checkOutput("zw_req_A", mem_req, 1);
    checkOutput("zw_addr_A", mem_addr, 32'h0);
    stepCycle();
    checkOutput("zw_valid_1", if_valid, 1);
    checkOutput("zw_pc_1", if_pc, 32'h4);
    checkOutput("zw_instr_1", if_instr, memWord(32'h0));
    stepCycle();
    checkOutput("zw_gap_1", if_valid, 0);
    checkOutput("zw_addr_2", mem_addr, 32'h4);
    checkOutput("zw_fetch_1", fetch_count, 1);
    stepCycle();
    checkOutput("zw_valid_2", if_valid, 1);
    checkOutput("zw_pc_2", if_pc, 32'h8);
    checkOutput("zw_instr_2", if_instr, memWord(32'h4));
    stepCycle();
    checkOutput("zw_gap_2", if_valid, 0);
    stepCycle();
    checkOutput("zw_valid_3", if_valid, 1);
    checkOutput("zw_pc_3", if_pc, 32'hC);
    stepCycle();
    checkOutput("zw_fetch_3", fetch_count, 3);

    // Three-cycle latency: address held for three request cycles.
    doReset(3);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("lat_req", mem_req, 1);
      checkOutput("lat_addr", mem_addr, 32'h0);
      checkOutput("lat_valid_lo", if_valid, 0);
    end
    stepCycle();
    checkOutput("lat_valid", if_valid, 1);
    checkOutput("lat_instr", if_instr, 32'hE3A01005);
    checkOutput("lat_pc", if_pc, 32'h4);

    // Freeze for four cycles in HOLD.
    applyStimulus(1, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("frz_valid", if_valid, 1);
      checkOutput("frz_instr", if_instr, 32'hE3A01005);
      checkOutput("frz_pc", if_pc, 32'h4);
      checkOutput("frz_req", mem_req, 0);
      checkOutput("frz_fetch", fetch_count, 0);
    end
    applyStimulus(0, 0, 32'h0);
    stepCycle();
    checkOutput("frz_rel_fetch", fetch_count, 1);
    checkOutput("frz_rel_addr", mem_addr, 32'h4);
    checkOutput("frz_rel_req", mem_req, 1);
    checkOutput("frz_rel_valid", if_valid, 0);

    // Redirect while the request to 0x8 is outstanding.
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("br_pre_valid", if_valid, 1);
    checkOutput("br_pre_pc", if_pc, 32'h8);
    stepCycle();
    checkOutput("br_issue_addr", mem_addr, 32'h8);
    checkOutput("br_issue_fetch", fetch_count, 2);
    applyStimulus(0, 1, 32'h100);
    stepCycle();
    applyStimulus(0, 0, 32'h0);
    checkOutput("br_disc_req", mem_req, 1);
    checkOutput("br_disc_addr", mem_addr, 32'h8);
    stepCycle();
    checkOutput("br_disc_addr2", mem_addr, 32'h8);
    checkOutput("br_disc_flush0", flush_count, 0);
    stepCycle();
    checkOutput("br_flush", flush_count, 1);
    checkOutput("br_new_addr", mem_addr, 32'h100);
    checkOutput("br_new_req", mem_req, 1);
    checkOutput("br_dropped", if_valid, 0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("br_tgt_valid", if_valid, 1);
    checkOutput("br_tgt_pc", if_pc, 32'h104);
    checkOutput("br_tgt_instr", if_instr, memWord(32'h100));

    // Branch together with freeze in HOLD, ack+branch in REQ, PC wrap.
    doReset(1);
    stepCycle();
    stepCycle();
    checkOutput("bf_hold", if_valid, 1);
    applyStimulus(1, 1, 32'h200);
    stepCycle();
    applyStimulus(0, 0, 32'h0);
    checkOutput("bf_valid", if_valid, 0);
    checkOutput("bf_flush", flush_count, 1);
    checkOutput("bf_addr", mem_addr, 32'h200);
    checkOutput("bf_req", mem_req, 1);
    checkOutput("bf_fetch", fetch_count, 0);
    stepCycle();
    checkOutput("bf_tgt_pc", if_pc, 32'h204);
    stepCycle();
    checkOutput("ab_addr_pre", mem_addr, 32'h204);
    applyStimulus(0, 1, 32'h300);
    stepCycle();
    applyStimulus(0, 0, 32'h0);
    checkOutput("ab_flush", flush_count, 2);
    checkOutput("ab_addr", mem_addr, 32'h300);
    checkOutput("ab_req", mem_req, 1);
    checkOutput("ab_valid", if_valid, 0);
    checkOutput("ab_fetch", fetch_count, 1);
    stepCycle();
    checkOutput("ab_tgt_pc", if_pc, 32'h304);
    applyStimulus(0, 1, 32'hFFFF_FFFC);
    stepCycle();
    applyStimulus(0, 0, 32'h0);
    checkOutput("wr_addr", mem_addr, 32'hFFFF_FFFC);
    checkOutput("wr_flush", flush_count, 3);
    stepCycle();
    checkOutput("wr_valid", if_valid, 1);
    checkOutput("wr_pc", if_pc, 32'h0);
    checkOutput("wr_instr", if_instr, memWord(32'hFFFF_FFFC));

    // Asynchronous reset while DISCARD holds an outstanding request.
    doReset(3);
    stepCycle();
    applyStimulus(0, 1, 32'h40);
    stepCycle();
    applyStimulus(0, 0, 32'h0);
    checkOutput("ar_disc_req", mem_req, 1);
    checkOutput("ar_disc_addr", mem_addr, 32'h0);
    #2;
    rst       = 1'b1;
    memEnable = 1'b0;
    #1;
    checkOutput("ar_async_req", mem_req, 0);
    checkOutput("ar_async_addr", mem_addr, 32'h0);
    checkOutput("ar_async_valid", if_valid, 0);
    stepCycle();
    stepCycle();
    rst      = 1'b0;
    strayAck = 1'b1;
    stepCycle();
    strayAck = 1'b0;
    checkOutput("ar_stray_req", mem_req, 1);
    checkOutput("ar_stray_addr", mem_addr, 32'h0);
    checkOutput("ar_stray_flush", flush_count, 0);
    checkOutput("ar_stray_fetch", fetch_count, 0);
    checkOutput("ar_stray_valid", if_valid, 0);
    stepCycle();
    checkOutput("ar_after_addr", mem_addr, 32'h0);
    checkOutput("ar_after_flush", flush_count, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Controls the instruction-fetch stage. It owns the program counter and runs a request/acknowledge handshake with an instruction memory of variable latency. It delivers fetched instructions to the IF/ID boundary and honours freeze from the hazard unit. It also handles branch redirects, including redirects that arrive while a memory request is still outstanding.

Parameters:
N, 32, address/instruction width
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
freeze  input  1  hazard stall; IF/ID must not consume this cycle
branch_taken  input  1  redirect request from EXE
branch_addr  input  N  redirect target
mem_req  output  1  instruction read request
mem_addr  output  N  read address, stable while mem_req=1
mem_ack  input  1  one-cycle pulse; mem_rdata valid in the same cycle
mem_rdata  input  N  instruction word
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_instr  output  N  fetched instruction
if_pc  output  N  fetch address + 4
fetch_count  output  CNT_W  instructions delivered (consumed by ID)
flush_count  output  CNT_W  instructions/responses discarded by redirect

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0, if_valid=0, if_instr=0, if_pc=0, both counters 0.
- Internal pc register holds the next address to fetch. All outputs are registered.
- States: IDLE, REQ, HOLD, DISCARD.
- IDLE -> REQ unconditionally next cycle. On entering REQ: mem_addr<=pc, mem_req<=1.
- REQ:
  - mem_req=1 is held.
  - ack and no branch: if_instr<=mem_rdata, if_pc<=mem_addr+4, if_valid<=1, pc<=mem_addr+4, mem_req<=0, go to HOLD. freeze does not block capture.
  - ack with branch_taken: drop the data, flush_count+1, pc<=branch_addr, re-enter REQ with mem_addr<=branch_addr.
  - branch_taken without ack: pc<=branch_addr, go to DISCARD. mem_req and mem_addr stay unchanged.
  - neither: stay in REQ.
- DISCARD:
  - mem_req stays 1 with the old mem_addr; a request is never withdrawn before ack.
  - Further branch_taken: pc<=newest branch_addr.
  - On ack: drop the data, flush_count+1, go to REQ with mem_addr<=pc, or branch_addr if a branch occurs in the same cycle.
- HOLD:
  - if_valid=1 and mem_req=0.
  - branch_taken (priority over freeze): if_valid<=0, flush_count+1, pc<=branch_addr, go to REQ.
  - Else freeze=1: hold all outputs and stay.
  - Else: instruction consumed this cycle. fetch_count+1, if_valid<=0, go to REQ with mem_addr<=pc.
- Throughput: at most one instruction every 2 cycles (REQ with immediate ack, then HOLD).
- Arithmetic:
  - pc+4 is modulo 2^N; 0xFFFFFFFC wraps to 0.
  - Counters are modulo 2^CNT_W and wrap silently.
- Reset mid-operation (any state, including an outstanding request): return immediately to reset values. A late mem_ack in IDLE is ignored and does not touch the counters.
- mem_ack in HOLD or IDLE is a protocol violation by memory: ignored, no state change.

Test Plan:
- Zero-wait memory (ack in same cycle as req), freeze=0: if_pc sequence 4, 8, 12 with if_valid high every other cycle. After 3 deliveries fetch_count=3.
- 3-cycle memory latency: mem_addr=0 is held for 3 cycles of mem_req. if_instr equals the returned word; if_valid rises the cycle after ack.
- freeze held 4 cycles in HOLD with instr 0xE3A01005: if_valid, if_instr and if_pc stay constant, mem_req=0. Release gives fetch_count+1 and next mem_addr=4.
- branch_taken to 0x100 one cycle after a 3-cycle request to 0x8 is issued: mem_addr stays 0x8 until ack. That data is dropped, flush_count=1, next mem_addr=0x100, and the delivered if_pc=0x104.
- branch_taken and freeze together in HOLD: if_valid drops next cycle, flush_count=1, mem_addr=branch_addr.
- rst asserted mid-DISCARD: outputs reach reset values asynchronously. A stray ack after release is ignored and counters remain 0.
